booth4_sequencer: RTL and testbench

Control and datapath-register stage of the radix-4 Booth multiplier. It sits around the 9-bit parallel adder: it holds the accumulator A, multiplier Q, extra bit Q₋₁ and multiplicand M, recodes Q bit-pairs into {c4,c3} operation codes for the adder, captures the adder's sum and performs the 2-bit arithmetic right shift. It sequences one signed 8×8 multiplication per start pulse and presents a 16-bit signed product.

---
 rtl/booth4_sequencer.sv | 163 ++++++++++++++++
 tb/tb_booth4_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/booth4_sequencer.sv
// Radix-4 Booth multiplier sequencer: holds A/Q/Q-1/M, recodes bit-pairs into
// {c4,c3} adder selects, captures the external 9-bit sum and shifts right by 2.
module booth4_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  multiplicand,
  input  logic [7:0]  multiplier,
  input  logic [8:0]  sum,
  output logic [8:0]  reg_A,
  output logic [8:0]  reg_M,
  output logic        c3,
  output logic        c4,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PRIME, S_PARK, S_DRIVE, S_ACC, S_SHIFT, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  regA_q, regA_d;
  logic [8:0]  regM_q, regM_d;
  logic [7:0]  regQ_q, regQ_d;
  logic        qm1_q, qm1_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] product_q, product_d;
  logic [1:0]  code_q, code_d;
  logic [1:0]  target_q, target_d;
  logic        ovf_q, ovf_d;

  logic [2:0]  digit;
  logic        goRecode;
  logic        fill;
  logic        opSign;
  logic [8:0]  shiftA;
  logic [7:0]  shiftQ;

  // Returns {zero, c4, c3} for a Booth triplet {q(2i+1), q(2i), q(2i-1)}.
  function automatic logic [2:0] recode(input logic [2:0] bits);
    case (bits)
      3'b000, 3'b111: recode = 3'b100;
      3'b001, 3'b010: recode = 3'b000;
      3'b011:         recode = 3'b001;
      3'b100:         recode = 3'b011;
      default:        recode = 3'b010;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      regA_q    <= '0;
      regM_q    <= '0;
      regQ_q    <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
      code_q    <= 2'b00;
      target_q  <= 2'b00;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      regA_q    <= regA_d;
      regM_q    <= regM_d;
      regQ_q    <= regQ_d;
      qm1_q     <= qm1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      code_q    <= code_d;
      target_q  <= target_d;
      ovf_q     <= ovf_d;
    end
  end

  // A -2M step on M=-128 leaves +256 in the 9-bit sum; ovf_q restores the true sign for the shift.
  assign fill   = regA_q[8] ^ ovf_q;
  assign shiftA = {fill, fill, regA_q[8:2]};
  assign shiftQ = {regA_q[1:0], regQ_q[7:2]};
  assign opSign = regM_q[8] ^ code_q[1];
  assign digit  = (state_q == S_SHIFT) ? recode(regQ_q[3:1])
                                       : recode({regQ_q[1:0], qm1_q});

  always_comb begin
    state_d   = state_q;
    regA_d    = regA_q;
    regM_d    = regM_q;
    regQ_d    = regQ_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    target_d  = target_q;
    ovf_d     = ovf_q;
    code_d    = 2'b00;
    goRecode  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        regM_d  = {multiplicand[7], multiplicand};
        regQ_d  = multiplier;
        regA_d  = '0;
        qm1_d   = 1'b0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        code_d  = 2'b01;
        state_d = S_PRIME;
      end
      S_PRIME: goRecode = 1'b1;
      S_PARK: begin
        code_d  = target_q;
        state_d = S_DRIVE;
      end
      S_DRIVE: begin
        code_d  = target_q;
        state_d = S_ACC;
      end
      S_ACC: begin
        regA_d  = sum;
        ovf_d   = (regA_q[8] == opSign) && (sum[8] != regA_q[8]);
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        regA_d = shiftA;
        regQ_d = shiftQ;
        qm1_d  = regQ_q[1];
        cnt_d  = cnt_q + 2'd1;
        ovf_d  = 1'b0;
        if (cnt_q == 2'd3) begin
          product_d = {shiftA[7:0], shiftQ};
          state_d   = S_DONE;
        end else begin
          goRecode = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (goRecode) begin
      if (digit[2]) begin
        state_d = S_SHIFT;
      end else begin
        target_d = digit[1:0];
        code_d   = ~digit[1:0];
        state_d  = S_PARK;
      end
    end
  end

  assign reg_A   = regA_q;
  assign reg_M   = regM_q;
  assign c4      = code_q[1];
  assign c3      = code_q[0];
  assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_booth4_sequencer.sv
// Bench for booth4_sequencer: a behavioural adder plus a radix-4 digit model
// predicting per-cycle busy/done/{c4,c3} and the final product.
module tb_booth4_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  multiplicand = '0;
  logic [7:0]  multiplier = '0;
  logic [8:0]  sum;
  logic [8:0]  reg_A, reg_M;
  logic        c3, c4, busy, done;
  logic [15:0] product;

  int checkCount = 0;
  int passCount  = 0;

  logic [1:0]  expCode [0:31];
  logic        expBusy [0:31];
  logic        expDone [0:31];
  int          doneCycle;
  logic [15:0] expProd;
  logic [8:0]  expA;
  logic [8:0]  addOp;

  booth4_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier), .sum(sum),
    .reg_A(reg_A), .reg_M(reg_M), .c3(c3), .c4(c4),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  // External 9-bit adder: A plus/minus M or 2M, wrapping modulo 512.
  assign addOp = c3 ? {reg_M[7:0], 1'b0} : reg_M;
  assign sum   = c4 ? (reg_A - addOp) : (reg_A + addOp);

  task automatic checkOutput(input string name, input int act, input int exp);
    checkCount++;
    if (act == exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Radix-4 digits d_i = -2*q[2i+1] + q[2i] + q[2i-1]; zero costs 1 cycle, nonzero 4.
  task automatic buildModel(input logic [7:0] m, input logic [7:0] q);
    int c, d, p, lo;
    logic [1:0] t;
    c = 1;
    expCode[1] = 2'b00;
    expCode[2] = 2'b01;
    c = 3;
    for (int i = 0; i < 4; i++) begin
      lo = (i == 0) ? 0 : int'(q[2*i-1]);
      d  = -2 * int'(q[2*i+1]) + int'(q[2*i]) + lo;
      if (d == 0) begin
        expCode[c] = 2'b00;
        c += 1;
      end else begin
        t = (d == 1) ? 2'b00 : (d == 2) ? 2'b01 : (d == -2) ? 2'b11 : 2'b10;
        expCode[c]   = ~t;
        expCode[c+1] = t;
        expCode[c+2] = t;
        expCode[c+3] = 2'b00;
        c += 4;
      end
    end
    doneCycle = c;
    expCode[c]   = 2'b00;
    expCode[c+1] = 2'b00;
    for (int k = 1; k <= c + 1; k++) begin
      expBusy[k] = (k < c);
      expDone[k] = (k == c);
    end
    p       = int'($signed(m)) * int'($signed(q));
    expProd = p[15:0];
    lo      = p >>> 8;
    expA    = lo[8:0];
  endtask

  // Caller is at a negedge of an IDLE cycle; returns at the negedge of the IDLE cycle after DONE.
  task automatic applyStimulus(input logic [7:0] m, input logic [7:0] q, input bit hold,
                               input int litProd, input int litCycle);
    buildModel(m, q);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    for (int c = 1; c <= doneCycle + 1; c++) begin
      @(negedge clk);
      checkOutput($sformatf("busy c%0d m=%0h q=%0h", c, m, q), int'(busy), int'(expBusy[c]));
      checkOutput($sformatf("done c%0d m=%0h q=%0h", c, m, q), int'(done), int'(expDone[c]));
      checkOutput($sformatf("code c%0d m=%0h q=%0h", c, m, q), int'({c4, c3}), int'(expCode[c]));
      if (c == 2) begin
        checkOutput("reg_M after LOAD", int'(reg_M), int'({m[7], m}));
        checkOutput("reg_A after LOAD", int'(reg_A), 0);
      end
      if (c >= doneCycle) begin
        checkOutput($sformatf("product m=%0h q=%0h", m, q), int'(product), int'(expProd));
        if (litProd >= 0) checkOutput("product literal", int'(product), litProd);
      end
      if (c == doneCycle) begin
        checkOutput($sformatf("final A m=%0h q=%0h", m, q), int'(reg_A), int'(expA));
        if (litCycle >= 0) checkOutput("done cycle literal", int'(done), 1);
      end
    end
    if (litCycle >= 0) checkOutput("model done cycle", doneCycle, litCycle);
  endtask

  initial begin
    int waited;
    logic [7:0] rm, rq;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset code", int'({c4, c3}), 0);
    checkOutput("reset reg_A", int'(reg_A), 0);
    checkOutput("reset reg_M", int'(reg_M), 0);
    checkOutput("reset product", int'(product), 0);
    rst = 1'b0;

    // Directed cases with hand-computed product and DONE cycle.
    applyStimulus(8'd7,   8'd3,   1'b0, 'h0015, 13);
    applyStimulus(8'h80,  8'h80,  1'b0, 'h4000, 10);
    applyStimulus(8'hFB,  8'd6,   1'b0, 'hFFE2, -1);
    applyStimulus(8'h55,  8'h00,  1'b0, 'h0000, 7);

    // start held high: one multiplication, one IDLE cycle, then a fresh LOAD.
    applyStimulus(8'd2, 8'd2, 1'b1, 'h0004, -1);
    @(negedge clk);
    checkOutput("held start relaunch busy", int'(busy), 1);
    start = 1'b0;
    waited = 0;
    while (!done && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("held start second done", int'(done), 1);
    checkOutput("held start second product", int'(product), 'h0004);
    @(negedge clk);

    // Reset in ACC of the first iteration (7x3: PARK c3, DRIVE c4, ACC c5).
    multiplicand = 8'd7;
    multiplier   = 8'd3;
    start        = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("pre-reset ACC code", int'({c4, c3}), 'b10);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid reset busy", int'(busy), 0);
    checkOutput("mid reset done", int'(done), 0);
    checkOutput("mid reset code", int'({c4, c3}), 0);
    checkOutput("mid reset reg_A", int'(reg_A), 0);
    checkOutput("mid reset reg_M", int'(reg_M), 0);
    checkOutput("mid reset product", int'(product), 0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("no done after reset", int'(done), 0);
    end
    applyStimulus(8'd3, 8'd3, 1'b0, 'h0009, -1);

    // Randomized operands, issued back to back.
    for (int n = 0; n < 40; n++) begin
      rm = 8'($urandom);
      rq = 8'($urandom);
      applyStimulus(rm, rq, 1'b0, -1, -1);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
